// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU into HI/LO,
// plus MTHI/MTLO, with a pipeline stall while an operation is in flight.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int W  = WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    addend;
    logic [W-1:0]    a_orig;
    logic            is_div;
    logic            neg_res;
    logic            neg_rem;
    logic            div0;

    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      sum, rs, diff;
    logic [2*W-1:0]  acc_next, prod;
    logic [W-1:0]    quo, rem, fin_hi, fin_lo;

    always_comb begin
        a_neg = ~op_i[0] & data1_i[W-1];
        b_neg = ~op_i[0] & data2_i[W-1];
        a_mag = a_neg ? -data1_i : data1_i;
        b_mag = b_neg ? -data2_i : data2_i;
        stall_o = (state == RUN) || ((state == IDLE) && start_i);
    end

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
        rs   = {acc[2*W-1:W], acc[W-1]};
        diff = rs - {1'b0, addend};
        if (is_div)
            acc_next = diff[W] ? {rs[W-1:0], acc[W-2:0], 1'b0}
                               : {diff[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_next = acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

        prod = neg_res ? -acc_next : acc_next;
        quo  = acc_next[W-1:0];
        rem  = acc_next[2*W-1:W];
        if (!is_div) begin
            fin_hi = prod[2*W-1:W];
            fin_lo = prod[W-1:0];
        end else if (div0) begin
            fin_hi = a_orig;
            fin_lo = '1;
        end else begin
            fin_hi = neg_rem ? -rem : rem;
            fin_lo = neg_res ? -quo : quo;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            addend  <= '0;
            a_orig  <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            busy_o  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= RUN;
                        busy_o  <= 1'b1;
                        count   <= '0;
                        is_div  <= op_i[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0    <= op_i[1] && (data2_i == '0);
                        a_orig  <= data1_i;
                        addend  <= op_i[1] ? b_mag : a_mag;
                        acc     <= {{W{1'b0}}, (op_i[1] ? a_mag : b_mag)};
                    end else begin
                        if (mthi_i) hi_o <= data1_i;
                        if (mtlo_i) lo_o <= data1_i;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        hi_o   <= fin_hi;
                        lo_o   <= fin_lo;
                    end
                end
                DONE: begin
                    // held start_i is deliberately ignored here to avoid re-launching
                    state <= IDLE;
                    if (mthi_i) hi_o <= data1_i;
                    if (mtlo_i) lo_o <= data1_i;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
